// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - operation and state encodings for the universal shift register
package shift_pkg;

  localparam logic [2:0] OP_HOLD = 3'd0;
  localparam logic [2:0] OP_LOAD = 3'd1;
  localparam logic [2:0] OP_SHL  = 3'd2;
  localparam logic [2:0] OP_SHR  = 3'd3;
  localparam logic [2:0] OP_ROL  = 3'd4;
  localparam logic [2:0] OP_ROR  = 3'd5;
  localparam logic [2:0] OP_ASR  = 3'd6;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  function automatic logic is_shift_op(input logic [2:0] op);
    return (op >= OP_SHL) && (op <= OP_ASR);
  endfunction

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational one-position shift/rotate/load step
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_q,
  input  logic [WIDTH-1:0] i_d,
  input  logic [2:0]       i_op,
  input  logic             i_sin,
  output logic [WIDTH-1:0] o_q,
  output logic             o_bit,
  output logic             o_moved
);

  always_comb begin
    o_q     = i_q;
    o_bit   = 1'b0;
    o_moved = 1'b0;
    case (i_op)
      OP_LOAD: o_q = i_d;
      OP_SHL: begin
        o_q     = {i_q[WIDTH-2:0], i_sin};
        o_bit   = i_q[WIDTH-1];
        o_moved = 1'b1;
      end
      OP_SHR: begin
        o_q     = {i_sin, i_q[WIDTH-1:1]};
        o_bit   = i_q[0];
        o_moved = 1'b1;
      end
      OP_ROL: begin
        o_q     = {i_q[WIDTH-2:0], i_q[WIDTH-1]};
        o_bit   = i_q[WIDTH-1];
        o_moved = 1'b1;
      end
      OP_ROR: begin
        o_q     = {i_q[0], i_q[WIDTH-1:1]};
        o_bit   = i_q[0];
        o_moved = 1'b1;
      end
      OP_ASR: begin
        o_q     = {i_q[WIDTH-1], i_q[WIDTH-1:1]};
        o_bit   = i_q[0];
        o_moved = 1'b1;
      end
      default: o_q = i_q;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// rtl/univ_shift_reg.sv - universal register with single-step and counted burst modes
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int  WIDTH = 8,
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] d,
  input  logic             sin,
  input  logic             start,
  input  logic [CW-1:0]    shamt,
  output logic [WIDTH-1:0] q,
  output logic             sout,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic [CW-1:0]    r_cnt;
  logic [2:0]       r_op;
  logic [WIDTH-1:0] r_q;
  logic             r_sout;
  logic             r_done;

  state_t           w_state_nxt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [2:0]       w_op_nxt;
  logic             w_done_nxt;
  logic             w_apply;
  logic [2:0]       w_step_op;
  logic [CW-1:0]    w_clamp;
  logic [WIDTH-1:0] w_step_q;
  logic             w_step_bit;
  logic             w_step_moved;

  assign w_clamp = (shamt > CW'(WIDTH)) ? CW'(WIDTH) : shamt;

  // One shifter serves both modes; only the operation source differs.
  shift_step #(.WIDTH(WIDTH)) u_step (
    .i_q     (r_q),
    .i_d     (d),
    .i_op    (w_step_op),
    .i_sin   (sin),
    .o_q     (w_step_q),
    .o_bit   (w_step_bit),
    .o_moved (w_step_moved)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_op_nxt    = r_op;
    w_done_nxt  = 1'b0;
    w_apply     = 1'b0;
    w_step_op   = op;
    if (en) begin
      case (r_state)
        IDLE: begin
          if (start) begin
            if (is_shift_op(op) && (w_clamp != '0)) begin
              w_op_nxt    = op;
              w_cnt_nxt   = w_clamp;
              w_state_nxt = BURST;
            end else begin
              // Zero-length shift bursts are a no-op; LOAD/HOLD run once.
              w_apply    = !is_shift_op(op);
              w_done_nxt = 1'b1;
            end
          end else begin
            w_apply = 1'b1;
          end
        end
        BURST: begin
          w_step_op = r_op;
          w_apply   = 1'b1;
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            w_state_nxt = IDLE;
            w_done_nxt  = 1'b1;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= OP_HOLD;
      r_q     <= '0;
      r_sout  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_op    <= w_op_nxt;
      r_done  <= w_done_nxt;
      if (w_apply) begin
        r_q <= w_step_q;
        if (w_step_moved) r_sout <= w_step_bit;
      end
    end
  end

  assign q    = r_q;
  assign sout = r_sout;
  assign busy = (r_state == BURST);
  assign done = r_done;

endmodule

// File: tb/tb_univ_shift_reg.sv
// tb/tb_univ_shift_reg.sv - directed self-checking bench for univ_shift_reg
module tb_univ_shift_reg;

  localparam int WIDTH = 8;
  localparam int CW    = 4;

  logic             clk;
  logic             rst;
  logic             en;
  logic [2:0]       op;
  logic [WIDTH-1:0] d;
  logic             sin;
  logic             start;
  logic [CW-1:0]    shamt;
  logic [WIDTH-1:0] q;
  logic             sout;
  logic             busy;
  logic             done;

  int n_cmp;
  int n_err;

  univ_shift_reg #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst   (rst),
    .en    (en),
    .op    (op),
    .d     (d),
    .sin   (sin),
    .start (start),
    .shamt (shamt),
    .q     (q),
    .sout  (sout),
    .busy  (busy),
    .done  (done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic state(input string tag, input logic [7:0] eq, input logic eb, input logic edn);
    chk({tag, ".q"}, 32'(q), 32'(eq));
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(edn));
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1; en = 1'b1; op = 3'd0; d = '0; sin = 1'b0; start = 1'b0; shamt = '0;
    step();
    state("reset", 8'h00, 1'b0, 1'b0);
    chk("reset.sout", 32'(sout), 32'd0);
    rst = 1'b0;

    // Single-step mode
    op = 3'd1; d = 8'h81; step();
    state("load81", 8'h81, 1'b0, 1'b0);
    op = 3'd2; sin = 1'b0; step();
    state("shl", 8'h02, 1'b0, 1'b0);
    chk("shl.sout", 32'(sout), 32'd1);
    op = 3'd1; d = 8'h80; step();
    chk("load80.sout_kept", 32'(sout), 32'd1);
    op = 3'd6; step();
    chk("asr.q", 32'(q), 32'hC0);
    chk("asr.sout", 32'(sout), 32'd0);
    op = 3'd7; d = 8'h11; step();
    chk("reserved.q", 32'(q), 32'hC0);

    // Burst ROR by 4 from F0, then back-to-back ROL by 1
    op = 3'd1; d = 8'hF0; step();
    op = 3'd5; shamt = 4'd4; start = 1'b1; step();
    state("ror.k", 8'hF0, 1'b1, 1'b0);
    start = 1'b0; op = 3'd1; d = 8'hFF; shamt = 4'd1; step();
    state("ror.k1", 8'h78, 1'b1, 1'b0);
    step();
    state("ror.k2", 8'h3C, 1'b1, 1'b0);
    step();
    state("ror.k3", 8'h1E, 1'b1, 1'b0);
    step();
    state("ror.k4", 8'h0F, 1'b0, 1'b1);
    chk("ror.sout", 32'(sout), 32'd0);
    op = 3'd4; shamt = 4'd1; start = 1'b1; step();
    state("b2b.accept", 8'h0F, 1'b1, 1'b0);
    start = 1'b0; op = 3'd0; step();
    state("b2b.done", 8'h1E, 1'b0, 1'b1);
    step();
    state("b2b.after", 8'h1E, 1'b0, 1'b0);

    // Clamped SHR burst with a 3-cycle stall
    op = 3'd1; d = 8'h00; step();
    op = 3'd3; sin = 1'b1; shamt = 4'd15; start = 1'b1; step();
    state("clamp.k", 8'h00, 1'b1, 1'b0);
    start = 1'b0; op = 3'd0;
    step(); step(); step();
    state("clamp.s3", 8'hE0, 1'b1, 1'b0);
    en = 1'b0;
    step(); step(); step();
    state("stall", 8'hE0, 1'b1, 1'b0);
    en = 1'b1;
    step();
    state("clamp.s4", 8'hF0, 1'b1, 1'b0);
    step(); step(); step();
    state("clamp.s7", 8'hFE, 1'b1, 1'b0);
    step();
    state("clamp.s8", 8'hFF, 1'b0, 1'b1);
    chk("clamp.sout", 32'(sout), 32'd0);
    step();
    state("clamp.after", 8'hFF, 1'b0, 1'b0);

    // Degenerate starts
    op = 3'd2; sin = 1'b0; shamt = 4'd0; start = 1'b1; step();
    state("zero.shl", 8'hFF, 1'b0, 1'b1);
    start = 1'b0; op = 3'd0; step();
    state("zero.after", 8'hFF, 1'b0, 1'b0);
    op = 3'd1; d = 8'h3C; shamt = 4'd5; start = 1'b1; step();
    state("start.load", 8'h3C, 1'b0, 1'b1);
    start = 1'b0; op = 3'd1; d = 8'h55; en = 1'b0; step();
    state("en_low", 8'h3C, 1'b0, 1'b0);
    en = 1'b1;

    // Reset in the middle of a burst
    op = 3'd1; d = 8'hA5; step();
    op = 3'd2; sin = 1'b0; shamt = 4'd6; start = 1'b1; step();
    start = 1'b0; op = 3'd0;
    step(); step(); step();
    state("rst.pre", 8'h28, 1'b1, 1'b0);
    rst = 1'b1; step();
    state("rst.mid", 8'h00, 1'b0, 1'b0);
    chk("rst.sout", 32'(sout), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst.no_done", 32'(done), 32'd0);
    end
    chk("rst.q_after", 32'(q), 32'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/univ_shift_reg.md
# univ_shift_reg

Parametrised WIDTH-bit universal register for the storage-element library; it generalises the single-bit transparent latch to a clocked, enabled register. Supports hold, parallel load, logical/arithmetic shift and rotate, applied either one step per enabled cycle or as an automatic multi-step burst. A small controller with busy/done signalling drives the bursts, so serialisers and barrel-shift-by-iteration users can hand off a shift count and wait.

## Interface
Parameters:
- WIDTH, 8, register width in bits (≥2)
- CW, $clog2(WIDTH+1), width of the shift-count field (derived, not overridden)

Ports:
- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  reset; one clock, reset synchronous and active-high
- en  in  1  global enable; low freezes all state (q, counter, FSM, sout) and suppresses done
- op  in  3  operation: 0 HOLD, 1 LOAD, 2 SHL, 3 SHR, 4 ROL, 5 ROR, 6 ASR, 7 reserved (treated as HOLD)
- d  in  WIDTH  parallel load data
- sin  in  1  serial input: enters bit 0 on SHL, bit WIDTH-1 on SHR
- start  in  1  request burst of op, shamt steps
- shamt  in  CW  burst step count; values > WIDTH clamp to WIDTH
- q  out  WIDTH  register contents
- sout  out  1  bit most recently shifted/rotated out (SHL: old msb; SHR/ROR/ASR: old lsb; ROL: old msb)
- busy  out  1  burst in progress
- done  out  1  one-cycle completion pulse

## Operation
- Reset: q=0, sout=0, busy=0, done=0, FSM IDLE, counter 0.
- Step semantics (one position): SHL q={q[W-2:0],sin}; SHR q={sin,q[W-1:1]}; ROL/ROR rotate; ASR q={q[W-1],q[W-1:1]}; LOAD q=d; HOLD unchanged. sout updates only on shift/rotate steps.
- FSM states: IDLE, BURST.
- IDLE, en=1, start=0: op applied once per cycle (single-step mode); done stays 0.
- IDLE, en=1, start=1, op∈{2..6}, clamped shamt=N≥1: latch op into op_r, counter=N, go BURST. No step at this edge.
- IDLE, start=1 with N=0 or op∈{0,1,7}: op executed once (LOAD/HOLD) or nothing (shift with N=0); done=1 next cycle; stay IDLE.
- BURST, en=1: perform op_r one step, counter−1; on reaching 0 → IDLE, done=1. sin sampled fresh every step.
- BURST: op, d, start, shamt ignored. en=0 stalls burst without losing progress.
- rst at any time (mid-burst included) overrides everything: outputs to reset values next edge, burst abandoned, no done.

## Timing
- start sampled at edge k (en=1) → busy=1 after edge k; steps occur at edges k+1..k+N (enabled edges only); busy=0 and done=1 after edge k+N; done=0 after edge k+N+1.
- Back-to-back: start may be asserted in the cycle done is high; accepted at that edge (FSM already IDLE).
- Single-step: q reflects op one edge after sampling; latency 1.
- All outputs registered; no combinational path from inputs to outputs.

## Structure
- Package shift_pkg: op encodings (OP_HOLD…OP_ASR) as localparams, state encodings IDLE/BURST.
- Sub-module shift_step: combinational one-position shifter (q, op, sin → next q, out bit), instantiated once and shared by single-step and burst paths.
- Top holds FSM, CW-bit down-counter, q/sout/done registers.

## Test plan
- Reset: drive rst=1 mid-burst (q=8'hA5, 3 steps left) → next edge q=0, busy=0, done=0, no later done pulse.
- Single-step: LOAD d=8'h81, then SHL sin=0 one cycle → q=8'h02, sout=1; then ASR with q=8'h80 → q=8'hC0, sout=0.
- Burst: q=8'hF0, start op=ROR shamt=4 → busy high 4 cycles, q=8'h0F after edge k+4, done single pulse, busy drops same cycle.
- Clamp and stall: shamt=15 with WIDTH=8, op=SHR sin=1, q=0 → 8 steps, q=8'hFF; en low for 3 cycles mid-burst → busy held, step count unchanged, total 8 steps.
- Degenerate start: start with shamt=0 op=SHL → q unchanged, done pulse next cycle, busy never high; start with op=LOAD d=8'h3C → q=8'h3C, done pulse.
- Back-to-back: new start (ROL, 1) during done cycle → accepted, second done exactly 2 cycles after first.
